// File: rtl/stack_ctrl_fsm_pkg.sv
// Shared opcodes, state encoding and sizing helper for the stack controller.
// STACK_CTRL_DUP_SWAP_EN adds the DUP/SWAP states.
package stack_ctrl_fsm_pkg;

   localparam int OP_PUSH = 1;
   localparam int OP_POP  = 2;
   localparam int OP_ADD  = 3;
   localparam int OP_OR   = 4;
   localparam int OP_SUB  = 5;
   localparam int OP_SLT  = 6;
   localparam int OP_NOR  = 7;
   localparam int OP_DUP  = 8;
   localparam int OP_SWAP = 9;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PUSH,
      S_POP,
      S_POP_A,
      S_POP_B,
      S_EXEC
`ifdef STACK_CTRL_DUP_SWAP_EN
      ,
      S_DUP,
      S_PUSH_A,
      S_PUSH_B
`endif
   } state_e;

   function automatic int depth_w(input int d);
      return $clog2(d + 1);
   endfunction

endpackage

// File: rtl/stack_ctrl_fsm_if.sv
// Instruction handshake between the instruction source and the controller.
// Master drives valid/opcode, slave answers with ready.
interface stack_ctrl_fsm_if #(
   parameter int OPC_W = 6
);
   logic             instr_valid;
   logic             instr_ready;
   logic [OPC_W-1:0] opcode;

   modport master (
      output instr_valid,
      output opcode,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  opcode,
      output instr_ready
   );
endinterface

// File: rtl/stack_ctrl_fsm_depth_counter.sv
// Saturating stack occupancy counter with synchronous clear.
// Produces depth plus full/empty flags.
module stack_depth_counter
   import stack_ctrl_fsm_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                      clock,
   input  logic                      clr_i,
   input  logic                      inc_i,
   input  logic                      dec_i,
   output logic [depth_w(DEPTH)-1:0] depth_o,
   output logic                      full_o,
   output logic                      empty_o
);
   localparam int DW = depth_w(DEPTH);

   logic [DW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_i && cnt_q != DW'(DEPTH))
         cnt_d = cnt_q + DW'(1);
      else if (dec_i && !inc_i && cnt_q != '0)
         cnt_d = cnt_q - DW'(1);
   end

   always_ff @(posedge clock) begin
      if (clr_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign depth_o = cnt_q;
   assign full_o  = (cnt_q == DW'(DEPTH));
   assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/stack_ctrl_fsm.sv
// Multi-cycle stack machine sequencer: pop/pop/exec+push for ALU ops.
// STACK_CTRL_DUP_SWAP_EN adds DUP=8, SWAP=9 and dup_swap_sel.
module stack_ctrl_fsm
   import stack_ctrl_fsm_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int OPC_W = 6,
   parameter int ALU_W = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   stack_ctrl_fsm_if.slave           bus,
   output logic                      push,
   output logic                      pop,
   output logic                      push_src,
   output logic [ALU_W-1:0]          alu_op,
   output logic [depth_w(DEPTH)-1:0] depth,
   output logic                      full,
   output logic                      empty,
   input  logic                      err_clear,
   output logic                      err_ovf,
   output logic                      err_unf,
`ifdef STACK_CTRL_DUP_SWAP_EN
   output logic                      dup_swap_sel,
`endif
   output logic                      err_ill
);
   localparam int DW = depth_w(DEPTH);

   state_e           state_q, state_d;
   logic [OPC_W-1:0] op_q, op_d;
   logic             ovf_d, unf_d, ill_d;
   logic             is_push, is_pop, is_alu;
   logic             is_dup, is_swap;
   logic             lt2;

   assign is_push = (bus.opcode == OPC_W'(OP_PUSH));
   assign is_pop  = (bus.opcode == OPC_W'(OP_POP));
   assign is_alu  = (bus.opcode >= OPC_W'(OP_ADD)) &&
                    (bus.opcode <= OPC_W'(OP_NOR));
`ifdef STACK_CTRL_DUP_SWAP_EN
   assign is_dup  = (bus.opcode == OPC_W'(OP_DUP));
   assign is_swap = (bus.opcode == OPC_W'(OP_SWAP));
`else
   assign is_dup  = 1'b0;
   assign is_swap = 1'b0;
`endif
   assign lt2 = (depth < DW'(2));

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      ovf_d   = err_ovf & ~err_clear;
      unf_d   = err_unf & ~err_clear;
      ill_d   = err_ill & ~err_clear;
      unique case (state_q)
         S_IDLE: begin
            if (bus.instr_valid) begin
               op_d = bus.opcode;
               // Rejected instructions stay in IDLE and leave depth alone
               unique case (1'b1)
                  is_push: if (full) ovf_d = 1'b1;
                           else      state_d = S_PUSH;
                  is_pop:  if (empty) unf_d = 1'b1;
                           else       state_d = S_POP;
                  is_alu:  if (lt2) unf_d = 1'b1;
                           else     state_d = S_POP_A;
`ifdef STACK_CTRL_DUP_SWAP_EN
                  is_dup:  if (empty)     unf_d = 1'b1;
                           else if (full) ovf_d = 1'b1;
                           else           state_d = S_DUP;
                  is_swap: if (lt2) unf_d = 1'b1;
                           else     state_d = S_POP_A;
`endif
                  default: ill_d = 1'b1;
               endcase
            end
         end
         S_POP_A: state_d = S_POP_B;
`ifdef STACK_CTRL_DUP_SWAP_EN
         S_POP_B: state_d = (op_q == OPC_W'(OP_SWAP)) ?
                            S_PUSH_A : S_EXEC;
         S_PUSH_A: state_d = S_PUSH_B;
`else
         S_POP_B: state_d = S_EXEC;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
         err_ill <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         err_ovf <= ovf_d;
         err_unf <= unf_d;
         err_ill <= ill_d;
      end
   end

   assign bus.instr_ready = (state_q == S_IDLE);
   assign pop      = (state_q == S_POP) || (state_q == S_POP_A) ||
                     (state_q == S_POP_B);
   assign push_src = (state_q == S_EXEC);
   assign alu_op   = (state_q == S_EXEC) ? ALU_W'(op_q[3:0]) : '0;
`ifdef STACK_CTRL_DUP_SWAP_EN
   assign push = (state_q == S_PUSH) || (state_q == S_EXEC) ||
                 (state_q == S_DUP) || (state_q == S_PUSH_A) ||
                 (state_q == S_PUSH_B);
   assign dup_swap_sel = (state_q == S_PUSH_B);
`else
   assign push = (state_q == S_PUSH) || (state_q == S_EXEC);
`endif

   stack_depth_counter #(.DEPTH(DEPTH)) u_depth (
      .clock   (clock),
      .clr_i   (reset),
      .inc_i   (push),
      .dec_i   (pop),
      .depth_o (depth),
      .full_o  (full),
      .empty_o (empty)
   );
endmodule
